score_tally: RTL and testbench
==============================

Name: score_tally

Overview:
- Downstream consumer of the lane droppers' score flags. Counts hits and misses per round and keeps score, combo and max combo.
- Converts the score to BCD with a sequential double-dabble engine, for the HEX/VGA score display.
- Runs on the same frame_clk as the droppers. Uses the same keycode start/return codes.

Parameters:
- N_LANES, 4, number of dropper lanes feeding hit/miss vectors.
- POINTS, 10, points per counted hit.
- SCORE_MAX, 9999, saturation ceiling of score (fits 14 bits).
- COMBO_MAX, 999, saturation ceiling of combo and max_combo (fits 10 bits).
- COMBO_THRESH, 10, combo level at which the bonus applies (only when COMBO_BONUS_EN is defined).

Ports:
- frame_clk  input  1  frame clock, shared with droppers.
- Reset  input  1  synchronous, active-high reset.
- keycode  input  8  primary USB keycode.
- hit  input  N_LANES  per-lane level-held score flag from each dropper.
- miss  input  N_LANES  per-lane level-held miss flag (lane finished without a hit).
- round_done  input  1  all lanes finished.
- score  output  14  binary score.
- score_bcd  output  16  four BCD digits of score, thousands in [15:12].
- bcd_valid  output  1  high when score_bcd matches score.
- combo  output  10  current consecutive-hit count.
- max_combo  output  10  best combo this round.
- hit_pulse  output  1  one-cycle strobe, high when ≥1 hit is counted.
- round_over  output  1  high in state Over.

Behaviour:
- Reset, at the next edge: state=Halted, score=0, combo=0, max_combo=0, score_bcd=0, bcd_valid=1, hit_pulse=0, round_over=0. Edge registers hit_q/miss_q=0. Converter Idle, pending=0.
- Edge detect:
  - hit_q and miss_q sample hit and miss every edge, in every state.
  - rise_h = hit & ~hit_q; rise_m = miss & ~miss_q.
  - Rises are acted on only in Play. Level-held flags therefore count once, and lines already high at round start never count.
- Per-lane conflict: a lane with rise_h and rise_m in the same cycle is treated as a hit only.
- Main FSM:
  - Halted: outputs hold their last round's values. keycode==8'h2C → Play. On that transition score, combo and max_combo are cleared.
  - Play: processes rises. round_done==1 → Over. Rises in the transition cycle are still processed.
  - Over: score, combo and max_combo frozen; round_over=1. keycode==8'h01 → Halted.
- Play update, single edge latency from the edge that samples the rise:
  - nh = popcount(rise_h); anym = |rise_m.
  - score ← min(score + nh*POINTS, SCORE_MAX).
  - c = min(combo + nh, COMBO_MAX).
  - max_combo ← max(max_combo, c).
  - combo ← anym ? 0 : c. Hits and misses in one cycle still award points, then break the combo.
  - hit_pulse=1 for exactly that cycle when nh>0; otherwise 0.
- BCD converter, states Idle/Shift/Commit:
  - Any edge where score's next value differs from its current value sets pending, and bcd_valid goes 0 at that edge.
  - Idle with pending: load shift register {16'b0, score}, clear pending, go to Shift.
  - Shift: 14 cycles, add-3 to each nibble ≥5, then shift left 1.
  - Commit: score_bcd ← result, go to Idle. bcd_valid ← ~pending.
  - A score change during Shift/Commit sets pending, forcing a re-conversion. An intermediate result may be committed, but bcd_valid stays 0 until a conversion completes with no change pending.
  - Latency with no further changes: score_bcd is valid 16 edges after score changes.
  - The clear on Halted→Play also triggers conversion, unless score was already 0.
- Saturation: score stops at 9999; combo and max_combo stop at 999. No wrap.
- Reset mid-conversion or mid-round: aborts immediately to the reset values.

Optional Feature:
- COMBO_BONUS_EN defined: each counted hit is worth 2*POINTS when the pre-update combo ≥ COMBO_THRESH. Score still saturates at SCORE_MAX.
- Not defined: every hit is worth POINTS and COMBO_THRESH is unused.

Test Plan:
- Reset, then keycode=8'h2C, hit[0] held high 20 cycles. Expect score=10, combo=1, hit_pulse high exactly one cycle. score_bcd=16'h0010 with bcd_valid=1 16 edges later.
- Same-cycle rises on hit[0], hit[1], hit[3]. Expect score +30, combo +3, one hit_pulse.
- Combo 5, then hit[2] rise and miss[1] rise in the same cycle. Expect score +10, max_combo=6, combo=0. Lane 2 hit and miss together counts as a hit only.
- Preload score 9990, then two single hits. Expect score=9999 both times, score_bcd=16'h9999. Combo counts without wrapping.
- Hits every 4 cycles during conversion. bcd_valid stays 0 until 16 edges after the last hit, then score_bcd equals final score.
- round_done=1 → round_over=1; hits ignored. keycode=8'h01 → Halted, values held. keycode=8'h2C → all cleared. hit line already high at start is not counted.

Source files
------------

// File: rtl/score_tally.sv
// -----------------------------------------------------------------------------
// score_tally
//
// Counts hit and miss flags from the lane droppers during a round. It keeps the
// score, the current combo and the best combo. A sequential double-dabble
// engine converts the binary score to four BCD digits for the score display.
//
// Optional feature macro: COMBO_BONUS_EN
//   defined   : a counted hit is worth 2*POINTS while the pre-update combo is
//               >= COMBO_THRESH. The COMBO_THRESH parameter exists only in this
//               build.
//   undefined : every hit is worth POINTS.
//
// Ports
//   frame_clk  in   frame clock, shared with the droppers
//   Reset      in   synchronous, active-high reset
//   keycode    in   [7:0] USB keycode (8'h2C starts a round, 8'h01 returns)
//   hit        in   [N_LANES-1:0] level-held per-lane hit flags
//   miss       in   [N_LANES-1:0] level-held per-lane miss flags
//   round_done in   all lanes finished
//   score      out  [13:0] binary score, saturates at SCORE_MAX
//   score_bcd  out  [15:0] BCD score, thousands digit in [15:12]
//   bcd_valid  out  score_bcd matches score
//   combo      out  [9:0] current consecutive-hit count
//   max_combo  out  [9:0] best combo this round
//   hit_pulse  out  one-cycle strobe when at least one hit is counted
//   round_over out  high while the round is over
// -----------------------------------------------------------------------------
module score_tally #(
    parameter int N_LANES   = 4,
    parameter int POINTS    = 10,
    parameter int SCORE_MAX = 9999,
    parameter int COMBO_MAX = 999
`ifdef COMBO_BONUS_EN
    ,
    parameter int COMBO_THRESH = 10
`endif
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic [7:0]         keycode,
    input  logic [N_LANES-1:0] hit,
    input  logic [N_LANES-1:0] miss,
    input  logic               round_done,
    output logic [13:0]        score,
    output logic [15:0]        score_bcd,
    output logic               bcd_valid,
    output logic [9:0]         combo,
    output logic [9:0]         max_combo,
    output logic               hit_pulse,
    output logic               round_over
);

    localparam int         SCORE_W    = 14;
    localparam int         COMBO_W    = 10;
    localparam int         NH_W       = $clog2(N_LANES + 1);
    localparam logic [7:0] KEY_START  = 8'h2C;
    localparam logic [7:0] KEY_RETURN = 8'h01;

    typedef enum logic [1:0] {S_HALTED, S_PLAY, S_OVER} state_t;
    typedef enum logic [1:0] {C_IDLE, C_SHIFT, C_COMMIT} conv_t;

    state_t               r_state;
    conv_t                r_cstate;
    logic [N_LANES-1:0]   r_hit_q, r_miss_q;
    logic [SCORE_W-1:0]   r_score;
    logic [COMBO_W-1:0]   r_combo, r_max_combo;
    logic                 r_hit_pulse, r_round_over;
    logic                 r_pending, r_bcd_valid;
    logic [15:0]          r_score_bcd;
    logic [SCORE_W+15:0]  r_sr;
    logic [3:0]           r_cnt;

    logic [N_LANES-1:0]   w_rise_h, w_rise_m;
    logic                 w_anym;
    logic [NH_W-1:0]      w_nh;
    logic [31:0]          w_pts, w_sum, w_csum;
    logic [SCORE_W-1:0]   w_score_add, w_score_next;
    logic [COMBO_W-1:0]   w_combo_add, w_max_add;
    logic                 w_score_chg;
    logic [SCORE_W+15:0]  w_adj;

    // A lane that rises on both flags in one cycle counts as a hit only, so its
    // miss is masked before it can break the combo.
    assign w_rise_h = hit & ~r_hit_q;
    assign w_rise_m = miss & ~r_miss_q & ~w_rise_h;
    assign w_anym   = |w_rise_m;

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_nh = '0;
        for (int i = 0; i < N_LANES; i++) begin
            w_nh = w_nh + NH_W'(w_rise_h[i]);
        end
    end

    always_comb begin
        w_pts = 32'(POINTS);
`ifdef COMBO_BONUS_EN
        if (32'(r_combo) >= 32'(COMBO_THRESH)) begin
            w_pts = 32'(2 * POINTS);
        end
`endif
        w_sum       = 32'(r_score) + 32'(w_nh) * w_pts;
        w_csum      = 32'(r_combo) + 32'(w_nh);
        w_score_add = (w_sum > 32'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : w_sum[SCORE_W-1:0];
        w_combo_add = (w_csum > 32'(COMBO_MAX)) ? COMBO_W'(COMBO_MAX) : w_csum[COMBO_W-1:0];
        w_max_add   = (w_combo_add > r_max_combo) ? w_combo_add : r_max_combo;

        // Next score value, shared by the FSM and the BCD change detector.
        w_score_next = r_score;
        case (r_state)
            S_HALTED: if (keycode == KEY_START) w_score_next = '0;
            S_PLAY:   w_score_next = w_score_add;
            default:  w_score_next = r_score;
        endcase
    end

    assign w_score_chg = (w_score_next != r_score);

    // Main round FSM with registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state      <= S_HALTED;
            r_hit_q      <= '0;
            r_miss_q     <= '0;
            r_score      <= '0;
            r_combo      <= '0;
            r_max_combo  <= '0;
            r_hit_pulse  <= 1'b0;
            r_round_over <= 1'b0;
        end else begin
            // Edge registers track the flags in every state, so a flag already
            // high when Play begins never produces a rise.
            r_hit_q     <= hit;
            r_miss_q    <= miss;
            r_hit_pulse <= 1'b0;
            r_score     <= w_score_next;
            case (r_state)
                S_HALTED: begin
                    if (keycode == KEY_START) begin
                        r_state     <= S_PLAY;
                        r_combo     <= '0;
                        r_max_combo <= '0;
                    end
                end
                S_PLAY: begin
                    r_combo     <= w_anym ? '0 : w_combo_add;
                    r_max_combo <= w_max_add;
                    r_hit_pulse <= (w_nh != '0);
                    if (round_done) begin
                        r_state      <= S_OVER;
                        r_round_over <= 1'b1;
                    end
                end
                S_OVER: begin
                    if (keycode == KEY_RETURN) begin
                        r_state      <= S_HALTED;
                        r_round_over <= 1'b0;
                    end
                end
                default: r_state <= S_HALTED;
            endcase
        end
    end

    // Double-dabble add-3 step on the four BCD nibbles above the binary field.
    always_comb begin
        w_adj = r_sr;
        for (int k = 0; k < 4; k++) begin
            if (r_sr[SCORE_W+4*k +: 4] >= 4'd5) begin
                w_adj[SCORE_W+4*k +: 4] = r_sr[SCORE_W+4*k +: 4] + 4'd3;
            end
        end
    end

    // BCD converter. A score change at any edge marks the display stale; the
    // engine keeps re-converting until a pass finishes with nothing pending.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_cstate    <= C_IDLE;
            r_pending   <= 1'b0;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_score_bcd <= '0;
            r_bcd_valid <= 1'b1;
        end else begin
            case (r_cstate)
                C_IDLE: begin
                    if (r_pending) begin
                        r_sr     <= {16'b0, r_score};
                        r_cnt    <= '0;
                        r_cstate <= C_SHIFT;
                    end
                end
                C_SHIFT: begin
                    r_sr  <= w_adj << 1;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'(SCORE_W - 1)) r_cstate <= C_COMMIT;
                end
                C_COMMIT: begin
                    r_score_bcd <= r_sr[SCORE_W+15:SCORE_W];
                    r_cstate    <= C_IDLE;
                end
                default: r_cstate <= C_IDLE;
            endcase

            // A change in this very cycle wins over the load-time clear and
            // over a commit, keeping the display marked stale.
            if (w_score_chg) begin
                r_pending   <= 1'b1;
                r_bcd_valid <= 1'b0;
            end else if (r_cstate == C_IDLE && r_pending) begin
                r_pending <= 1'b0;
            end else if (r_cstate == C_COMMIT) begin
                r_bcd_valid <= ~r_pending;
            end
        end
    end

    assign score      = r_score;
    assign score_bcd  = r_score_bcd;
    assign bcd_valid  = r_bcd_valid;
    assign combo      = r_combo;
    assign max_combo  = r_max_combo;
    assign hit_pulse  = r_hit_pulse;
    assign round_over = r_round_over;

endmodule

// File: tb/tb_score_tally.sv
// -----------------------------------------------------------------------------
// tb_score_tally
//
// Self-checking bench for score_tally. A behavioural model predicts score,
// combo, max_combo, hit_pulse and round_over for every edge; the prediction is
// queued when inputs are driven and compared after the edge. BCD output is
// checked against a decimal conversion of the model score whenever it claims
// to be valid, and must stay invalid for 16 edges after any score change.
// -----------------------------------------------------------------------------
module tb_score_tally;

    logic        frame_clk;
    logic        Reset;
    logic [7:0]  keycode;
    logic [3:0]  hit, miss;
    logic        round_done;
    logic [13:0] score;
    logic [15:0] score_bcd;
    logic        bcd_valid;
    logic [9:0]  combo, max_combo;
    logic        hit_pulse, round_over;

    score_tally dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .hit        (hit),
        .miss       (miss),
        .round_done (round_done),
        .score      (score),
        .score_bcd  (score_bcd),
        .bcd_valid  (bcd_valid),
        .combo      (combo),
        .max_combo  (max_combo),
        .hit_pulse  (hit_pulse),
        .round_over (round_over)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int score;
        int combo;
        int maxc;
        bit pulse;
        bit over;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Model state: 0 Halted, 1 Play, 2 Over.
    int         m_state, m_score, m_combo, m_max, since_chg;
    logic [3:0] m_hq, m_mq;
    int         pulse_cnt;
    int         first_valid;
    int         saved;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return 16'(((v / 1000) % 10) << 12 | ((v / 100) % 10) << 8 |
                   ((v / 10) % 10) << 4 | (v % 10));
    endfunction

    // Predict the registers after the coming edge from the inputs now driven.
    task automatic mdl_step();
        exp_t       e;
        int         old, nh, c, pts;
        logic [3:0] rh, rm;
        old     = m_score;
        e.pulse = 1'b0;
        if (Reset) begin
            m_state   = 0;
            m_score   = 0;
            m_combo   = 0;
            m_max     = 0;
            m_hq      = '0;
            m_mq      = '0;
            since_chg = 100;
        end else begin
            rh = hit & ~m_hq;
            rm = miss & ~m_mq & ~rh;
            if (m_state == 0) begin
                if (keycode == 8'h2C) begin
                    m_state = 1;
                    m_score = 0;
                    m_combo = 0;
                    m_max   = 0;
                end
            end else if (m_state == 1) begin
                nh  = $countones(rh);
                pts = 10;
`ifdef COMBO_BONUS_EN
                if (m_combo >= 10) pts = 20;
`endif
                m_score = m_score + nh * pts;
                if (m_score > 9999) m_score = 9999;
                c = m_combo + nh;
                if (c > 999) c = 999;
                if (c > m_max) m_max = c;
                m_combo = (rm != 0) ? 0 : c;
                e.pulse = (nh > 0);
                if (round_done) m_state = 2;
            end else if (keycode == 8'h01) begin
                m_state = 0;
            end
            m_hq = hit;
            m_mq = miss;
            if (m_score != old) since_chg = 0;
            else if (since_chg < 100) since_chg++;
        end
        e.score = m_score;
        e.combo = m_combo;
        e.maxc  = m_max;
        e.over  = (m_state == 2);
        sb_q.push_back(e);
    endtask

    // One clock: queue the prediction, let the edge pass, compare.
    task automatic cycle();
        exp_t e;
        mdl_step();
        @(posedge frame_clk);
        #1;
        e = sb_q.pop_front();
        check("score", 32'(score), e.score);
        check("combo", 32'(combo), e.combo);
        check("max_combo", 32'(max_combo), e.maxc);
        check("hit_pulse", 32'(hit_pulse), 32'(e.pulse));
        check("round_over", 32'(round_over), 32'(e.over));
        if (since_chg < 16) check("bcd_valid_early", 32'(bcd_valid), 0);
        if (bcd_valid) check("score_bcd", 32'(score_bcd), 32'(to_bcd(m_score)));
        if (hit_pulse) pulse_cnt++;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bcd_valid && n < 40) begin
            cycle();
            n++;
        end
        check(tag, 32'(bcd_valid), 1);
    endtask

    initial begin
        Reset      = 1'b1;
        keycode    = 8'h00;
        hit        = '0;
        miss       = '0;
        round_done = 1'b0;
        pulse_cnt  = 0;
        cycle();
        cycle();
        check("rst_score_bcd", 32'(score_bcd), 0);
        check("rst_bcd_valid", 32'(bcd_valid), 1);
        check("rst_score", 32'(score), 0);
        Reset = 1'b0;

        // Start a round, hold hit[0] for 20 cycles: one count, BCD after 16.
        keycode = 8'h2C;
        cycle();
        keycode     = 8'h00;
        pulse_cnt   = 0;
        first_valid = -1;
        hit         = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (first_valid < 0 && bcd_valid) first_valid = i;
        end
        check("t1_score", 32'(score), 10);
        check("t1_combo", 32'(combo), 1);
        check("t1_pulses", 32'(pulse_cnt), 1);
        check("t1_latency", 32'(first_valid), 16);
        check("t1_bcd", 32'(score_bcd), 32'h0010);
        hit = '0;
        cycle();

        // Three simultaneous rises.
        pulse_cnt = 0;
        hit       = 4'b1011;
        cycle();
        check("t2_score", 32'(score), 40);
        check("t2_combo", 32'(combo), 4);
        hit = '0;
        cycle();
        check("t2_pulses", 32'(pulse_cnt), 1);

        // Build combo 5, then hit and miss together: points kept, combo broken.
        hit = 4'b0001;
        cycle();
        hit = '0;
        cycle();
        hit  = 4'b0100;
        miss = 4'b0110;
        cycle();
        check("t3_score", 32'(score), 60);
        check("t3_max", 32'(max_combo), 6);
        check("t3_combo", 32'(combo), 0);
        hit  = '0;
        miss = '0;
        cycle();
        // Hit and miss rising on the same lane only: treated as a hit.
        hit  = 4'b1000;
        miss = 4'b1000;
        cycle();
        check("t3_conflict_combo", 32'(combo), 1);
        hit  = '0;
        miss = '0;
        cycle();

        // Hits every 4 cycles while the converter is busy.
        for (int k = 0; k < 5; k++) begin
            hit = 4'b0001;
            cycle();
            hit = '0;
            cycle();
            cycle();
            cycle();
        end
        wait_valid("t5_valid_seen");
        check("t5_score", 32'(score), 120);
        check("t5_bcd", 32'(score_bcd), 32'h0120);

        // End of round: frozen, hits ignored, return keeps values.
        round_done = 1'b1;
        cycle();
        round_done = 1'b0;
        check("t6_round_over", 32'(round_over), 1);
        saved = score;
        hit   = 4'b1111;
        cycle();
        hit = '0;
        cycle();
        check("t6_frozen", 32'(score), 32'(saved));
        keycode = 8'h01;
        cycle();
        keycode = 8'h00;
        cycle();
        check("t6_halted_over", 32'(round_over), 0);
        check("t6_held_max", 32'(max_combo), 6);
        // Restart with hit[0] already high: cleared and not counted.
        hit = 4'b0001;
        cycle();
        keycode = 8'h2C;
        cycle();
        keycode = 8'h00;
        cycle();
        cycle();
        check("t6_clr_score", 32'(score), 0);
        check("t6_clr_max", 32'(max_combo), 0);
        hit = '0;
        cycle();

        // Preload to 9990 through quad hits, then saturate.
        for (int k = 0; k < 249; k++) begin
            hit = 4'b1111;
            cycle();
            hit = '0;
            cycle();
        end
        hit = 4'b0111;
        cycle();
        hit = '0;
        cycle();
        check("t4_preload", 32'(score), 9990);
        check("t4_combo_sat", 32'(combo), 999);
        for (int k = 0; k < 2; k++) begin
            hit = 4'b0001;
            cycle();
            hit = '0;
            cycle();
            check("t4_score_sat", 32'(score), 9999);
            check("t4_combo_hold", 32'(combo), 999);
        end
        wait_valid("t4_valid_seen");
        check("t4_bcd", 32'(score_bcd), 32'h9999);

        // Reset in the middle of a conversion.
        round_done = 1'b1;
        cycle();
        round_done = 1'b0;
        keycode    = 8'h01;
        cycle();
        keycode = 8'h2C;
        cycle();
        keycode = 8'h00;
        cycle();
        cycle();
        cycle();
        check("t7_converting", 32'(bcd_valid), 0);
        Reset = 1'b1;
        cycle();
        check("t7_rst_valid", 32'(bcd_valid), 1);
        check("t7_rst_bcd", 32'(score_bcd), 0);
        Reset = 1'b0;
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
